ex_mem_reg: RTL and testbench

- Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core.
- Captures the EX results every cycle:
  - destination register address, write enable and write data;
  - HI/LO write enable and HI/LO values.
- Honours the global stall vector and the exception flush.
- Holds the multiply-accumulate intermediate (hilo_o, cnt_o) across the stall cycle that madd/msub insert, then feeds it back to EX on the following cycle.

---
 rtl/ex_mem_reg.sv | 72 +++++++
 tb/tb_ex_mem_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall bubble, flush and madd/msub accumulator hold.
// Optional load/store opcode and store-data path enabled by defining EX_MEM_MEMOP_EN.
module ex_mem_reg #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      stall,
    input  logic            flush,
    input  logic [AW-1:0]   ex_wd,
    input  logic            ex_wreg,
    input  logic [DW-1:0]   ex_wdata,
    input  logic            ex_whilo,
    input  logic [DW-1:0]   ex_hi,
    input  logic [DW-1:0]   ex_lo,
    input  logic [2*DW-1:0] hilo_i,
    input  logic [1:0]      cnt_i,
`ifdef EX_MEM_MEMOP_EN
    input  logic [7:0]      ex_aluop,
    input  logic [DW-1:0]   ex_reg2,
    output logic [7:0]      mem_aluop,
    output logic [DW-1:0]   mem_reg2,
`endif
    output logic [AW-1:0]   mem_wd,
    output logic            mem_wreg,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_whilo,
    output logic [DW-1:0]   mem_hi,
    output logic [DW-1:0]   mem_lo,
    output logic [2*DW-1:0] hilo_o,
    output logic [1:0]      cnt_o
);
    // EX stalled while MEM runs: bubble downstream, keep the accumulator for EX
    logic bubble, load;
    assign bubble = stall[3] && !stall[4];
    assign load   = !stall[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (flush || bubble || load) begin
            mem_wd    <= (flush || bubble) ? '0   : ex_wd;
            mem_wreg  <= (flush || bubble) ? 1'b0 : ex_wreg;
            mem_wdata <= (flush || bubble) ? '0   : ex_wdata;
            mem_whilo <= (flush || bubble) ? 1'b0 : ex_whilo;
            mem_hi    <= (flush || bubble) ? '0   : ex_hi;
            mem_lo    <= (flush || bubble) ? '0   : ex_lo;
            hilo_o    <= (!flush && bubble) ? hilo_i : '0;
            cnt_o     <= (!flush && bubble) ? cnt_i  : '0;
        end
    end

`ifdef EX_MEM_MEMOP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_aluop <= '0;
            mem_reg2  <= '0;
        end else if (flush || bubble || load) begin
            mem_aluop <= (flush || bubble) ? '0 : ex_aluop;
            mem_reg2  <= (flush || bubble) ? '0 : ex_reg2;
        end
    end
`endif
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: table-driven check of ex_mem_reg with a queue of expected output bundles.
module tb_ex_mem_reg;
    localparam int OW = 5 + 1 + 32 + 1 + 32 + 32 + 64 + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic        ex_whilo = 1'b0;
    logic [31:0] ex_hi = '0, ex_lo = '0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  cnt_i = '0;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
`ifdef EX_MEM_MEMOP_EN
    logic [7:0]  ex_aluop = '0, mem_aluop;
    logic [31:0] ex_reg2 = '0, mem_reg2;
`endif

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
`ifdef EX_MEM_MEMOP_EN
        .ex_aluop(ex_aluop), .ex_reg2(ex_reg2), .mem_aluop(mem_aluop), .mem_reg2(mem_reg2),
`endif
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst) assert (!(stall[4] && !stall[3])) else $error("illegal stall vector %b", stall);

    logic [OW-1:0] out_bus;
    assign out_bus = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o};

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [OW-1:0] exp;
    } vec_t;

    int n_vec = 0, n_bad = 0;
    logic [OW-1:0] sb[$];

    function automatic logic [OW-1:0] ob(logic [4:0] wd, logic wreg, logic [31:0] wdata, logic whilo,
                                         logic [31:0] hi, logic [31:0] lo, logic [63:0] hilo, logic [1:0] cnt);
        return {wd, wreg, wdata, whilo, hi, lo, hilo, cnt};
    endfunction

    function automatic vec_t mk(string name, logic [5:0] st, logic fl, logic [4:0] wd, logic wreg,
                                logic [31:0] wdata, logic whilo, logic [31:0] hi, logic [31:0] lo,
                                logic [63:0] hilo, logic [1:0] cnt, logic [OW-1:0] exp);
        vec_t v;
        v.name = name; v.stall = st; v.flush = fl; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
        v.whilo = whilo; v.hi = hi; v.lo = lo; v.hilo = hilo; v.cnt = cnt; v.exp = exp;
        return v;
    endfunction

    task automatic drive(vec_t v);
        stall = v.stall; flush = v.flush; ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata;
        ex_whilo = v.whilo; ex_hi = v.hi; ex_lo = v.lo; hilo_i = v.hilo; cnt_i = v.cnt;
        sb.push_back(v.exp);
    endtask

    task automatic check(string name);
        logic [OW-1:0] e;
        e = sb.pop_front();
        n_vec++;
        if (out_bus !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, out_bus, e);
        end
    endtask

    localparam logic [63:0] P1 = 64'h0000_0001_0000_0002;
    localparam logic [63:0] P2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [OW-1:0] Z = '0;
    vec_t tbl[14];

    initial begin
        tbl[0]  = mk("normal",      6'b000000, 0, 5'd3, 1, 32'h12345678, 1, 32'h1, 32'h2, 64'h0, 2'd0,
                     ob(5'd3, 1, 32'h12345678, 1, 32'h1, 32'h2, 64'h0, 2'd0));
        tbl[1]  = mk("bubble_acc",  6'b001111, 0, 5'd7, 1, 32'h0000FFFF, 1, 32'h9, 32'h8, P1, 2'd1,
                     ob(5'd0, 0, 32'h0, 0, 32'h0, 32'h0, P1, 2'd1));
        tbl[2]  = mk("resume",      6'b000000, 0, 5'd4, 1, 32'hCAFEF00D, 0, 32'h0, 32'h0, P2, 2'd2,
                     ob(5'd4, 1, 32'hCAFEF00D, 0, 32'h0, 32'h0, 64'h0, 2'd0));
        tbl[3]  = mk("load_a5",     6'b000000, 0, 5'd9, 1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h0, 2'd0,
                     ob(5'd9, 1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h0, 2'd0));
        tbl[4]  = mk("hold1",       6'b011111, 0, 5'd1, 0, 32'h11111111, 0, 32'h5, 32'h6, P2, 2'd3,
                     ob(5'd9, 1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h0, 2'd0));
        tbl[5]  = mk("hold2",       6'b011111, 0, 5'd2, 1, 32'h22222222, 0, 32'h5, 32'h6, P1, 2'd1,
                     ob(5'd9, 1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h0, 2'd0));
        tbl[6]  = mk("hold3",       6'b011111, 0, 5'd3, 1, 32'h33333333, 1, 32'h5, 32'h6, P2, 2'd2,
                     ob(5'd9, 1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h0, 2'd0));
        tbl[7]  = mk("flush_prio",  6'b001111, 1, 5'd5, 1, 32'h55555555, 1, 32'h7, 32'h7, P2, 2'd1, Z);
        tbl[8]  = mk("bubble_cnt2", 6'b001111, 0, 5'd6, 1, 32'h66666666, 1, 32'h7, 32'h7, P2, 2'd2,
                     ob(5'd0, 0, 32'h0, 0, 32'h0, 32'h0, P2, 2'd2));
        tbl[9]  = mk("hold_acc",    6'b011111, 0, 5'd6, 1, 32'h77777777, 1, 32'h7, 32'h7, P1, 2'd1,
                     ob(5'd0, 0, 32'h0, 0, 32'h0, 32'h0, P2, 2'd2));
        tbl[10] = mk("load_hi",     6'b100000, 0, 5'd31, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'h0, P1, 2'd3,
                     ob(5'd31, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'h0, 64'h0, 2'd0));
        tbl[11] = mk("flush_run",   6'b000000, 1, 5'd8, 1, 32'h88888888, 1, 32'h1, 32'h1, P1, 2'd1, Z);
        tbl[12] = mk("hold_zero",   6'b111111, 0, 5'd8, 1, 32'h99999999, 1, 32'h1, 32'h1, P1, 2'd1, Z);
        tbl[13] = mk("flush_hold",  6'b011111, 1, 5'd8, 1, 32'h99999999, 1, 32'h1, 32'h1, P1, 2'd1, Z);

        ex_wd = 5'd17; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(Z);
        check("reset_state");
        rst = 1'b1;
        sb.push_back(ob(5'd17, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0, 64'h0, 2'd0));
        @(posedge clk); #1;
        check("post_reset_load");

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i]);
            @(posedge clk); #1;
            check(tbl[i].name);
        end

        drive(mk("pre_async", 6'b001111, 0, 5'd2, 1, 32'h1234, 1, 32'h3, 32'h4, P1, 2'd1,
                 ob(5'd0, 0, 32'h0, 0, 32'h0, 32'h0, P1, 2'd1)));
        @(posedge clk); #1;
        check("pre_async");
        #2 rst = 1'b0;
        #1;
        sb.push_back(Z);
        check("async_reset");
        @(posedge clk); #1;
        sb.push_back(Z);
        check("reset_held");
        rst = 1'b1;
        drive(mk("after_async", 6'b000000, 0, 5'd10, 1, 32'h0BADF00D, 0, 32'h0, 32'h0, P2, 2'd2,
                 ob(5'd10, 1, 32'h0BADF00D, 0, 32'h0, 32'h0, 64'h0, 2'd0)));
        @(posedge clk); #1;
        check("after_async");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
